// File: rtl/zacore_prefetch.sv
// zacore_prefetch: sequential instruction prefetcher with a QUEUE_DEPTH-entry
// FIFO of {inst, pc, misaligned}, PC redirect and flush support.
// Ports: i_clk/i_rst (async, active-high); o_fetch_req/o_fetch_addr and
// i_fetch_ack/i_inst_read to instruction memory; i_redirect/i_redirect_addr,
// i_invalidate from execute; i_stall, o_valid/o_inst/o_pc/o_misaligned to decode.
// Optional macro ZACORE_PREFETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// produces a marker entry and halts fetching until the next redirect.
module zacore_prefetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_fetch_req,
   input  logic        i_fetch_ack,
   output logic [31:0] o_fetch_addr,
   input  logic [31:0] i_inst_read,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_addr,
   input  logic        i_invalidate,
   input  logic        i_stall,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_misaligned
);

   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(QUEUE_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [31:0]   pc_q, pc_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   count_q, count_d;

   logic [31:0]   inst_mem [QUEUE_DEPTH];
   logic [31:0]   pc_mem   [QUEUE_DEPTH];

   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [31:0]   wr_inst;
   logic [31:0]   wr_pc;

   logic          halted;
   logic          push;
   logic          pop;

`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
   logic          mis_mem [QUEUE_DEPTH];
   logic          wr_mis;
   logic          halted_q, halted_d;

   assign halted       = halted_q;
   assign o_misaligned = mis_mem[rptr_q];
`else
   logic          unused_addr_lo;

   assign halted         = 1'b0;
   assign o_misaligned   = 1'b0;
   assign unused_addr_lo = ^i_redirect_addr[1:0];
`endif

   // Request is gated by reset so an in-flight request drops immediately.
   assign o_fetch_req  = !i_rst && !halted && (count_q < DEPTH_C);
   assign o_fetch_addr = pc_q;
   assign o_valid      = (count_q != '0);
   assign o_inst       = inst_mem[rptr_q];
   assign o_pc         = pc_mem[rptr_q];

   assign push = o_fetch_req && i_fetch_ack;
   assign pop  = o_valid && !i_stall;

   always_comb begin
      pc_d    = pc_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = wptr_q;
      wr_inst = i_inst_read;
      wr_pc   = pc_q;
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
      wr_mis   = 1'b0;
      halted_d = halted_q;
`endif
      if (i_redirect) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
         pc_d    = {i_redirect_addr[31:2], 2'b00};
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
         halted_d = 1'b0;
         if (i_redirect_addr[1:0] != 2'b00) begin
            // Marker entry goes to slot 0 of the freshly flushed FIFO.
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_inst  = '0;
            wr_pc    = i_redirect_addr;
            wr_mis   = 1'b1;
            wptr_d   = PTR_ONE;
            count_d  = CNT_ONE;
            halted_d = 1'b1;
            pc_d     = i_redirect_addr;
         end
`endif
      end else if (i_invalidate) begin
         // Any ack this cycle is dropped; pc holds so it is refetched.
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + PTR_ONE;
            pc_d   = pc_q + 32'd4;
         end
         if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q    <= RESET_PC;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
         halted_q <= 1'b0;
`endif
      end else begin
         pc_q    <= pc_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
         halted_q <= halted_d;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            inst_mem[i] <= '0;
            pc_mem[i]   <= '0;
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
            mis_mem[i]  <= 1'b0;
`endif
         end
      end else if (wr_en) begin
         inst_mem[wr_idx] <= wr_inst;
         pc_mem[wr_idx]   <= wr_pc;
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
         mis_mem[wr_idx]  <= wr_mis;
`endif
      end
   end

endmodule

// File: tb/tb_zacore_prefetch.sv
// Testbench for zacore_prefetch: table vectors, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_zacore_prefetch;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          DEPTH = 4;
   localparam logic [31:0] K     = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req;
   logic        fetch_ack = 1'b0;
   logic [31:0] fetch_addr;
   logic [31:0] inst_read = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        invalidate = 1'b0;
   logic        stall = 1'b0;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        mis;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   zacore_prefetch #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst),
      .o_fetch_req(fetch_req), .i_fetch_ack(fetch_ack),
      .o_fetch_addr(fetch_addr), .i_inst_read(inst_read),
      .i_redirect(redirect), .i_redirect_addr(redirect_addr),
      .i_invalidate(invalidate), .i_stall(stall),
      .o_valid(valid), .o_inst(inst), .o_pc(pc), .o_misaligned(mis)
   );

   // Reference model: a plain queue of fetched entries plus fetch PC.
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      bit          mis;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          m_halt;

`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc   = RPC;
      m_halt = 1'b0;
   endtask

   task automatic model_compare();
      bit exp_req;
      exp_req = !m_halt && (m_q.size() < DEPTH);
      chk("m_req", 32'(fetch_req), 32'(exp_req));
      chk("m_addr", fetch_addr, m_pc);
      chk("m_valid", 32'(valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("m_inst", inst, m_q[0].inst);
         chk("m_pc", pc, m_q[0].pc);
         chk("m_mis", 32'(mis), 32'(m_q[0].mis));
      end
   endtask

   task automatic model_update(input bit ack, input logic [31:0] din,
                               input bit rd, input logic [31:0] ra,
                               input bit inv, input bit stl);
      bit req;
      ent_t e;
      req = !m_halt && (m_q.size() < DEPTH);
      if (rd) begin
         m_q.delete();
         m_halt = 1'b0;
         m_pc   = ra & 32'hFFFF_FFFC;
         if (TRAP && ra[1:0] != 2'b00) begin
            e.inst = '0; e.pc = ra; e.mis = 1'b1;
            m_q.push_back(e);
            m_halt = 1'b1;
            m_pc   = ra;
         end
      end else if (inv) begin
         m_q.delete();
      end else begin
         if (m_q.size() != 0 && !stl) void'(m_q.pop_front());
         if (req && ack) begin
            e.inst = din; e.pc = m_pc; e.mis = 1'b0;
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // Called at posedge+1; leaves at the next posedge+1.
   task automatic step(input bit ack, input logic [31:0] din,
                       input bit rd, input logic [31:0] ra,
                       input bit inv, input bit stl);
      fetch_ack = ack; inst_read = din; redirect = rd;
      redirect_addr = ra; invalidate = inv; stall = stl;
      #1;
      model_compare();
      @(posedge clk);
      model_update(ack, din, rd, ra, inv, stl);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fetch_ack = 1'b0; redirect = 1'b0; invalidate = 1'b0; stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(fetch_req), 32'd0);
      chk("rst_addr", fetch_addr, RPC);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_mis", 32'(mis), 32'd0);
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit          rst;
      bit          ack;
      bit          stall;
      bit          req;
      logic [31:0] addr;
      bit          valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // Streaming from reset, then fill under stall and drain.
      vecs = '{
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1, 32'h100},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 32'h104},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h108},
         '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100},
         '{1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100},
         '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h100},
         '{1'b0, 1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h100},
         '{1'b0, 1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 32'h100},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 32'h104},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h114, 1'b1, 32'h108},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h118, 1'b1, 32'h10C},
         '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11C, 1'b1, 32'h110}
      };

      do_reset();
      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            do_reset();
         end else begin
            fetch_ack = vecs[i].ack; stall = vecs[i].stall;
            redirect = 1'b0; invalidate = 1'b0;
            #1;
            chk("t_req", 32'(fetch_req), 32'(vecs[i].req));
            chk("t_addr", fetch_addr, vecs[i].addr);
            chk("t_valid", 32'(valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
               chk("t_pc", pc, vecs[i].pc);
               chk("t_inst", inst, vecs[i].pc ^ K);
            end
            #1;
            step(vecs[i].ack, vecs[i].addr ^ K, 1'b0, '0, 1'b0, vecs[i].stall);
         end
      end

      // Redirect in the same cycle as the ack of 0x108.
      do_reset();
      step(1'b1, 32'h100 ^ K, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h104 ^ K, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h108 ^ K, 1'b1, 32'h2000, 1'b0, 1'b1);
      chk("rd_valid", 32'(valid), 32'd0);
      chk("rd_req", 32'(fetch_req), 32'd1);
      chk("rd_addr", fetch_addr, 32'h2000);
      step(1'b1, 32'h2000 ^ K, 1'b0, '0, 1'b0, 1'b1);
      chk("rd_pc", pc, 32'h2000);
      chk("rd_inst", inst, 32'h2000 ^ K);

      // Invalidate with 3 entries held and an ack at 0x10C.
      do_reset();
      step(1'b1, 32'h100 ^ K, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h104 ^ K, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h108 ^ K, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h10C ^ K, 1'b0, '0, 1'b1, 1'b1);
      chk("inv_valid", 32'(valid), 32'd0);
      chk("inv_addr", fetch_addr, 32'h10C);
      step(1'b1, 32'h10C ^ K, 1'b0, '0, 1'b0, 1'b0);
      chk("inv_pc", pc, 32'h10C);

      // Misaligned redirect target.
      do_reset();
      step(1'b1, 32'h100 ^ K, 1'b1, 32'h2002, 1'b0, 1'b1);
`ifdef ZACORE_PREFETCH_MISALIGN_TRAP_EN
      chk("mis_valid", 32'(valid), 32'd1);
      chk("mis_flag", 32'(mis), 32'd1);
      chk("mis_pc", pc, 32'h2002);
      chk("mis_req", 32'(fetch_req), 32'd0);
      repeat (3) step(1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0);
      chk("mis_req_halt", 32'(fetch_req), 32'd0);
      step(1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 1'b0);
      chk("mis_req_resume", 32'(fetch_req), 32'd1);
      chk("mis_addr_resume", fetch_addr, 32'h3000);
`else
      chk("mis_req", 32'(fetch_req), 32'd1);
      chk("mis_addr", fetch_addr, 32'h2000);
      step(1'b1, 32'h2000 ^ K, 1'b0, '0, 1'b0, 1'b0);
      chk("mis_pc", pc, 32'h2000);
      chk("mis_flag", 32'(mis), 32'd0);
`endif

      // PC wrap at the top of the address space.
      step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
      repeat (4) step(1'b1, $urandom, 1'b0, '0, 1'b0, 1'b0);

      // Asynchronous reset between clock edges.
      do_reset();
      repeat (3) step(1'b1, $urandom, 1'b0, '0, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_req", 32'(fetch_req), 32'd0);
      chk("arst_addr", fetch_addr, RPC);
      do_reset();

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ra;
         bit rd, inv;
         rd  = ($urandom_range(0, 99) < 3);
         inv = ($urandom_range(0, 99) < 3);
         ra  = $urandom & 32'h0000_FFFF;
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         step(($urandom_range(0, 9) < 7), $urandom, rd, ra, inv,
              ($urandom_range(0, 9) < 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
